// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared widths, feeder FSM states and request/response records.
package sqrt_pkg;
  localparam int X_W = 8;
  localparam int R_W = 4;
  localparam int T_W = 4;
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;
  typedef struct packed {
    logic [X_W-1:0] x;
    logic [T_W-1:0] tag;
  } req_t;
  typedef struct packed {
    logic [R_W-1:0] root;
    logic [X_W-1:0] x;
    logic [T_W-1:0] tag;
    logic           err;
  } rsp_t;
endpackage

// File: rtl/sqrt_feeder_fifo.sv
// sqrt_feeder_fifo: power-of-two request buffer holding {x,tag} entries.
module sqrt_feeder_fifo
  import sqrt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  req_t data_i,
  input  logic pop_i,
  output req_t data_o,
  output logic full_o,
  output logic empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;
  req_t mem_q [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    empty_o = wr_q == rd_q;
    full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    wr_d    = do_push ? wr_q + (AW+1)'(1) : wr_q;
    rd_d    = do_pop ? rd_q + (AW+1)'(1) : rd_q;
    data_o  = mem_q[rd_q[AW-1:0]];
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/sqrt_feeder.sv
// sqrt_feeder: buffers radicands and feeds them one at a time to an external sqrt core.
module sqrt_feeder
  import sqrt_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           req_valid_i,
  output logic           req_ready_o,
  input  logic [X_W-1:0] req_x_i,
  input  logic [T_W-1:0] req_tag_i,
  output logic           core_start_o,
  output logic [X_W-1:0] core_x_o,
  input  logic           core_done_i,
  input  logic [R_W-1:0] core_root_i,
  output logic           rsp_valid_o,
  input  logic           rsp_ready_i,
  output logic [R_W-1:0] rsp_root_o,
  output logic [X_W-1:0] rsp_x_o,
  output logic [T_W-1:0] rsp_tag_o,
  output logic           rsp_err_o
);
  localparam int CW = $clog2(TIMEOUT);
  state_t         state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [T_W-1:0] tag_q, tag_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  rsp_t           rsp_q, rsp_d;
  req_t           fifo_in, fifo_out;
  logic           fifo_full, fifo_empty, pop;
  always_comb fifo_in = '{x: req_x_i, tag: req_tag_i};
  sqrt_feeder_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (req_valid_i),
    .data_i (fifo_in),
    .pop_i  (pop),
    .data_o (fifo_out),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
    end
  end
  // Done is tested before the timeout so a coincident completion is kept.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    rsp_d   = rsp_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          x_d     = fifo_out.x;
          tag_d   = fifo_out.tag;
          rsp_d   = '{root: '0, x: fifo_out.x, tag: fifo_out.tag, err: 1'b0};
          state_d = (fifo_out.x == '0) ? S_RESP : S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_done_i) begin
          rsp_d   = '{root: core_root_i, x: x_q, tag: tag_q, err: 1'b0};
          state_d = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_d   = '{root: '0, x: x_q, tag: tag_q, err: 1'b1};
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP:  state_d = rsp_ready_i ? S_IDLE : S_RESP;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    req_ready_o  = !fifo_full;
    core_start_o = state_q == S_START;
    core_x_o     = x_q;
    rsp_valid_o  = state_q == S_RESP;
    rsp_root_o   = rsp_q.root;
    rsp_x_o      = rsp_q.x;
    rsp_tag_o    = rsp_q.tag;
    rsp_err_o    = rsp_q.err;
  end
endmodule

// File: tb/tb_sqrt_feeder.sv
// tb_sqrt_feeder: scoreboard bench for sqrt_feeder with a delay-programmable core model.
module tb_sqrt_feeder;
  localparam int TO = 16;
  logic       clk = 0, rst_i = 1;
  logic       req_valid_i = 0, req_ready_o;
  logic [7:0] req_x_i = 0;
  logic [3:0] req_tag_i = 0;
  logic       core_start_o, core_done_i;
  logic [7:0] core_x_o;
  logic [3:0] core_root = 0;
  logic       core_done_m = 0, stray_done = 0;
  logic       rsp_valid_o, rsp_ready_i = 1, rsp_err_o;
  logic [3:0] rsp_root_o, rsp_tag_o;
  logic [7:0] rsp_x_o;
  int total = 0, bad = 0;
  int core_delay = 0, left = 0;
  typedef struct {
    logic [3:0] root;
    logic [7:0] x;
    logic [3:0] tag;
    logic       err;
  } exp_t;
  exp_t q[$];

  assign core_done_i = core_done_m | stray_done;

  sqrt_feeder #(.FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_x_i(req_x_i), .req_tag_i(req_tag_i),
    .core_start_o(core_start_o), .core_x_o(core_x_o), .core_done_i(core_done_i), .core_root_i(core_root),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_root_o(rsp_root_o), .rsp_x_o(rsp_x_o),
    .rsp_tag_o(rsp_tag_o), .rsp_err_o(rsp_err_o)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [3:0] isqrt(input logic [7:0] x);
    int r = 0;
    while ((r + 1) * (r + 1) <= int'(x)) r++;
    return 4'(r);
  endfunction

  // Core model: done pulses core_delay cycles after the start pulse; delay 0 means never.
  initial forever begin
    @(negedge clk);
    core_done_m = 0;
    if (rst_i) left = 0;
    else begin
      if (left > 0) begin
        left--;
        if (left == 0) begin
          core_done_m = 1;
          core_root = isqrt(core_x_o);
        end
      end
      if (core_start_o && core_delay > 0) left = core_delay;
    end
  end

  // Response monitor: scoreboard compare on handshake, stability while stalled.
  logic [16:0] snap;
  logic        held = 0;
  exp_t        e;
  initial forever begin
    @(negedge clk);
    #1;
    if (rst_i || !rsp_valid_o) held = 0;
    else begin
      if (held) begin
        total++;
        if ({rsp_root_o, rsp_x_o, rsp_tag_o, rsp_err_o} !== snap) begin
          bad++;
          $display("FAIL rsp_stable got=%h want=%h", {rsp_root_o, rsp_x_o, rsp_tag_o, rsp_err_o}, snap);
        end
      end
      snap = {rsp_root_o, rsp_x_o, rsp_tag_o, rsp_err_o};
      held = !rsp_ready_i;
      if (rsp_ready_i) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL rsp_unexpected got x=%0d tag=%0d root=%0d", rsp_x_o, rsp_tag_o, rsp_root_o);
        end else begin
          e = q.pop_front();
          if (rsp_root_o !== e.root || rsp_x_o !== e.x || rsp_tag_o !== e.tag || rsp_err_o !== e.err) begin
            bad++;
            $display("FAIL rsp got root=%0d x=%0d tag=%0d err=%0d want root=%0d x=%0d tag=%0d err=%0d",
                     rsp_root_o, rsp_x_o, rsp_tag_o, rsp_err_o, e.root, e.x, e.tag, e.err);
          end
        end
      end
    end
  end

  task automatic push(input logic [7:0] x, input logic [3:0] tag, input logic [3:0] root,
                      input logic err, input bit expect_rsp);
    int n = 0;
    while (!req_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o) begin
      total++;
      bad++;
      $display("FAIL push_ready got=0 want=1 within 200 cycles");
    end
    req_valid_i = 1;
    req_x_i = x;
    req_tag_i = tag;
    if (expect_rsp) q.push_back('{root, x, tag, err});
    @(negedge clk);
    req_valid_i = 0;
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
  endtask

  task automatic test_reset;
    rst_i = 1;
    repeat (3) @(negedge clk);
    total += 4;
    if (req_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready_o); end
    if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid_o); end
    if (core_start_o !== 1'b0 || core_x_o !== 8'd0) begin
      bad++; $display("FAIL reset_core got start=%b x=%0d want 0/0", core_start_o, core_x_o);
    end
    if ({rsp_root_o, rsp_x_o, rsp_tag_o, rsp_err_o} !== 17'd0) begin
      bad++; $display("FAIL reset_rsp_fields got=%h want=0", {rsp_root_o, rsp_x_o, rsp_tag_o, rsp_err_o});
    end
    rst_i = 0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int starts = 0, xbad = 0;
    core_delay = 10;
    push(8'd16, 4'd3, 4'd4, 1'b0, 1);
    for (int i = 0; i < 60 && q.size() > 0; i++) begin
      if (core_start_o) starts++;
      if (starts > 0 && core_x_o !== 8'd16) xbad++;
      @(negedge clk);
    end
    wait_drain(5);
    total += 2;
    if (starts != 1) begin bad++; $display("FAIL basic_starts got=%0d want=1", starts); end
    if (xbad != 0) begin bad++; $display("FAIL basic_core_x unstable_cycles=%0d want=0", xbad); end
  endtask

  task automatic test_zero;
    int starts = 0;
    push(8'd0, 4'd7, 4'd0, 1'b0, 1);
    total += 2;
    if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL zero_early got=%b want=0 at N+1", rsp_valid_o); end
    if (core_start_o) starts++;
    @(negedge clk);
    if (rsp_valid_o !== 1'b1) begin bad++; $display("FAIL zero_latency got=%b want=1 at N+2", rsp_valid_o); end
    repeat (4) begin
      if (core_start_o) starts++;
      @(negedge clk);
    end
    wait_drain(5);
    total++;
    if (starts != 0) begin bad++; $display("FAIL zero_starts got=%0d want=0", starts); end
  endtask

  task automatic test_fifo_full;
    core_delay = 3;
    rsp_ready_i = 0;
    for (int i = 1; i <= 5; i++) push(8'(i), 4'(i), isqrt(8'(i)), 1'b0, 1);
    total++;
    if (req_ready_o !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", req_ready_o); end
    repeat (8) @(negedge clk);
    total += 2;
    if (req_ready_o !== 1'b0) begin bad++; $display("FAIL full_ready_hold got=%b want=0", req_ready_o); end
    if (rsp_valid_o !== 1'b1) begin bad++; $display("FAIL full_rsp_waiting got=%b want=1", rsp_valid_o); end
    rsp_ready_i = 1;
    wait_drain(100);
  endtask

  task automatic test_timeout;
    int k = 0;
    core_delay = 0;
    push(8'd200, 4'd9, 4'd0, 1'b1, 1);
    for (int i = 0; i < 10 && !core_start_o; i++) @(negedge clk);
    while (!rsp_valid_o && k < 200) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k - 1 != TO) begin bad++; $display("FAIL timeout_wait_cycles got=%0d want=%0d", k - 1, TO); end
    wait_drain(10);
    core_delay = 2;
    push(8'd49, 4'd1, 4'd7, 1'b0, 1);
    wait_drain(40);
  endtask

  task automatic test_coincide;
    int seen = 0;
    core_delay = TO;
    push(8'd81, 4'd5, 4'd9, 1'b0, 1);
    wait_drain(60);
    stray_done = 1;
    @(negedge clk);
    stray_done = 0;
    repeat (10) begin
      if (rsp_valid_o || core_start_o) seen++;
      @(negedge clk);
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL stray_done activity_cycles=%0d want=0", seen); end
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    core_delay = 0;
    push(8'd4, 4'd1, 4'd2, 1'b0, 0);
    push(8'd9, 4'd2, 4'd3, 1'b0, 0);
    push(8'd25, 4'd3, 4'd5, 1'b0, 0);
    repeat (3) @(negedge clk);
    rst_i = 1;
    #1;
    total += 3;
    if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
      bad++; $display("FAIL midreset_hs got ready=%b valid=%b want 1/0", req_ready_o, rsp_valid_o);
    end
    if (core_start_o !== 1'b0 || core_x_o !== 8'd0) begin
      bad++; $display("FAIL midreset_core got start=%b x=%0d want 0/0", core_start_o, core_x_o);
    end
    if ({rsp_root_o, rsp_x_o, rsp_tag_o, rsp_err_o} !== 17'd0) begin
      bad++; $display("FAIL midreset_rsp got=%h want=0", {rsp_root_o, rsp_x_o, rsp_tag_o, rsp_err_o});
    end
    repeat (2) @(negedge clk);
    rst_i = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid_o || core_start_o) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL midreset_leftover activity_cycles=%0d want=0", seen); end
    core_delay = 4;
    push(8'd255, 4'd2, 4'd15, 1'b0, 1);
    wait_drain(40);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_fifo_full();
    test_timeout();
    test_coincide();
    test_reset_mid();
    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL final_pending got=%0d want=0", q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sqrt_feeder.md
SQRT_FEEDER -- requirements
Module: sqrt_feeder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of buffered requests (power of two, >=2).
REQ-002 Parameter TIMEOUT, default 64, max WAIT cycles before the job is aborted.
REQ-003 clk_i  input  1  sole clock, rising-edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 req_valid_i  input  1  request offered.
REQ-006 req_ready_o  output  1  request FIFO not full.
REQ-007 req_x_i  input  8  radicand.
REQ-008 req_tag_i  input  4  caller tag, returned unchanged.
REQ-009 core_start_o  output  1  one-cycle launch pulse to the sqrt core.
REQ-010 core_x_o  output  8  radicand to the core, held stable from launch until job end.
REQ-011 core_done_i  input  1  core finished; root valid this cycle.
REQ-012 core_root_i  input  4  integer floor square root from the core.
REQ-013 rsp_valid_o  output  1  response available.
REQ-014 rsp_ready_i  input  1  consumer accepts response.
REQ-015 rsp_root_o, rsp_x_o, rsp_tag_o, rsp_err_o  output  4/8/4/1  root, echoed radicand, tag, timeout flag.

Function
REQ-016 Request transfer SHALL occur on a rising edge with req_valid_i & req_ready_o; the entry is poppable the following cycle.
REQ-017 FIFO SHALL allow simultaneous push and pop when neither full nor empty; req_ready_o SHALL be 0 when FIFO_DEPTH entries are held; pointers wrap modulo FIFO_DEPTH.
REQ-018 FSM states SHALL be IDLE, START, WAIT, RESP.
REQ-019 IDLE: when FIFO is non-empty, pop one entry and latch x and tag; x==0 -> RESP with root 0, err 0, no core launch; else -> START.
REQ-020 START: core_start_o=1 for exactly this cycle, clear wait counter -> WAIT.
REQ-021 WAIT: counter increments each cycle; core_done_i=1 latches core_root_i, err 0 -> RESP.
REQ-022 WAIT: counter reaching TIMEOUT-1 without core_done_i -> RESP with root 0, err 1.
REQ-023 Done and timeout in the same cycle: done SHALL win.
REQ-024 core_done_i outside WAIT SHALL be ignored.
REQ-025 RESP: rsp_valid_o=1 with all rsp fields stable; on rsp_ready_i=1 -> IDLE; fields SHALL NOT change while rsp_valid_o=1 and rsp_ready_i=0.
REQ-026 Best-case latency: push cycle N -> rsp_valid_o at N+2 for x==0; N+3+core cycles for x!=0.
REQ-027 Responses SHALL leave in request order; only one job in flight.

Reset
REQ-028 While rst_i=1: state IDLE, FIFO empty, counter 0, core_start_o=0, core_x_o=0, rsp_valid_o=0, rsp_root_o=0, rsp_x_o=0, rsp_tag_o=0, rsp_err_o=0, req_ready_o=1.
REQ-029 Reset mid-job SHALL discard the in-flight job and all FIFO entries; no response is emitted for them.

Structure
REQ-030 Package sqrt_pkg SHALL hold the feeder state enum, the 8-bit radicand/4-bit root/4-bit tag width constants and the response struct.
REQ-031 The request buffer SHALL be a sub-module sqrt_feeder_fifo (parameterised depth, {x,tag} payload).

Verification
REQ-032 Push x=16, tag=3; core model returns 4 after 10 cycles -> one core_start_o pulse, core_x_o=16 throughout, rsp root=4 tag=3 err=0.
REQ-033 Push x=0, tag=7 at cycle N -> no core_start_o, rsp_valid_o at N+2, root=0 err=0.
REQ-034 Hold rsp_ready_i=0, push 5 requests x=1..5 -> req_ready_o low after 4 stored (plus 1 in flight); release -> roots 1,1,1,2,2 in order.
REQ-035 Core model never asserts done, x=200 -> rsp at TIMEOUT cycles after START with root=0 err=1; next job proceeds normally.
REQ-036 Done and timeout coincide, root=9 -> err=0 root=9; stray core_done_i in IDLE -> no response.
REQ-037 Assert rst_i during WAIT with 2 entries queued -> all outputs at reset values, no response after release, next push x=255 -> root 15.
